// File: rtl/shift_register.sv
// Registered left shifter: dataOut <= dataIn << SHIFT with synchronous active-low reset.
// Define SHIFTREG_PIPE_EN to add a second output register stage (latency 2).
module shift_register #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2
) (
  input  logic [WIDTH-1:0] dataIn,
  input  logic             CLK,
  output logic [WIDTH-1:0] dataOut,
  input  logic             RSTn
);

  if (SHIFT < 0 || SHIFT >= WIDTH) begin : g_bad_shift
    $error("shift_register: SHIFT must lie in 0..WIDTH-1");
  end

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] stage1_d;
  logic [WIDTH-1:0] stage1_q;

  // Pure wiring: low SHIFT bits are zero fill, top SHIFT input bits fall off.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi < SHIFT) begin : g_zero
      assign shifted[gi] = 1'b0;
    end else begin : g_move
      assign shifted[gi] = dataIn[gi-SHIFT];
    end
  end

  always_comb begin
    stage1_d = shifted;
    if (!RSTn) begin
      stage1_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    stage1_q <= stage1_d;
  end

`ifdef SHIFTREG_PIPE_EN
  logic [WIDTH-1:0] stage2_d;
  logic [WIDTH-1:0] stage2_q;

  // Reset clears both stages on the same edge, so no stale word leaks out afterwards.
  always_comb begin
    stage2_d = stage1_q;
    if (!RSTn) begin
      stage2_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    stage2_q <= stage2_d;
  end

  assign dataOut = stage2_q;
`else
  assign dataOut = stage1_q;
`endif

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register: driver pushes expected words, monitor pops and checks.
module tb_shift_register;

  localparam int WIDTH = 32;
  localparam int SHIFT = 2;
`ifdef SHIFTREG_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [WIDTH-1:0] exp;
    bit               chk;
    string            name;
  } item_t;

  logic             CLK;
  logic             RSTn;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;

  int compared   = 0;
  int mismatched = 0;

  item_t      sb_q[$];
  bit         hist_rst[$];
  logic [31:0] hist_din[$];

  shift_register #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .dataIn (dataIn),
    .CLK    (CLK),
    .dataOut(dataOut),
    .RSTn   (RSTn)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: output after an edge is 0 if reset was seen at any of the last LAT
  // edges, otherwise the word captured LAT edges ago times 2**SHIFT (mod 2**WIDTH).
  function automatic item_t model(string name);
    item_t it;
    bit any_rst = 1'b0;
    int n = (hist_rst.size() < LAT) ? hist_rst.size() : LAT;
    for (int i = 0; i < n; i++) any_rst |= hist_rst[i];
    it.name = name;
    if (any_rst) begin
      it.exp = '0;
      it.chk = 1'b1;
    end else if (hist_rst.size() < LAT) begin
      it.exp = '0;
      it.chk = 1'b0;
    end else begin
      it.exp = hist_din[LAT-1] * (32'd1 << SHIFT);
      it.chk = 1'b1;
    end
    return it;
  endfunction

  task automatic step(input bit rst, input logic [31:0] din, input bit glitch, input string name);
    @(negedge CLK);
    RSTn   = ~rst;
    dataIn = din;
    hist_rst.push_front(rst);
    hist_din.push_front(din);
    if (hist_rst.size() > LAT) begin
      void'(hist_rst.pop_back());
      void'(hist_din.pop_back());
    end
    sb_q.push_back(model(name));
    if (glitch) begin
      #1 dataIn = ~din;
      RSTn = rst;
      #1 dataIn = $urandom;
      #1 dataIn = din;
      RSTn = ~rst;
    end
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: dataOut=0x%08h expected=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: dataOut=0x%08h", name, act);
    end
  endtask

  // Monitor: after each edge pop one expectation; re-check just before the next edge
  // to catch any change caused by mid-cycle input activity.
  initial begin
    item_t it;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        if (it.chk) begin
          check(it.name, dataOut, it.exp);
          #8;
          check({it.name, "_hold"}, dataOut, it.exp);
        end
      end
    end
  end

  initial begin
    RSTn   = 1'b0;
    dataIn = '0;

    // Reset with all-ones input, then release.
    step(1'b1, 32'hFFFF_FFFF, 1'b0, "reset0");
    step(1'b1, 32'hFFFF_FFFF, 1'b0, "reset1");
    step(1'b0, 32'hFFFF_FFFF, 1'b0, "release");

    // Basic and MSB-loss patterns.
    step(1'b0, 32'h0000_0001, 1'b0, "basic1");
    step(1'b0, 32'hFFFF_FFFF, 1'b0, "basic2");
    step(1'b0, 32'h0000_FFFF, 1'b0, "basic3");
    step(1'b0, 32'hC000_0001, 1'b0, "msb_c0");
    step(1'b0, 32'h4000_0000, 1'b0, "msb_40");
    step(1'b0, 32'h2000_0000, 1'b0, "top_bit");

    // Mid-cycle glitches on data and reset must not reach dataOut.
    step(1'b0, 32'h1234_5678, 1'b1, "glitch1");
    step(1'b0, 32'hA5A5_A5A5, 1'b1, "glitch2");

    // Reset mid-stream.
    step(1'b0, 32'h0000_0001, 1'b0, "stream1");
    step(1'b1, 32'h0000_0002, 1'b0, "stream2");
    step(1'b0, 32'h0000_0003, 1'b0, "stream3");
    step(1'b0, 32'h0000_0000, 1'b0, "flush");

    // Randomized traffic with occasional reset and glitches.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(15) == 0), $urandom, ($urandom_range(7) == 0), $sformatf("rand%0d", i));
    end
    step(1'b0, 32'h0, 1'b0, "tail0");
    step(1'b0, 32'h0, 1'b0, "tail1");

    repeat (LAT + 2) @(posedge CLK);
    #2;
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
